uzed_led_sequencer: RTL and testbench



---
 rtl/uzed_led_sequencer.sv | 175 +++++++++++++++++
 tb/tb_uzed_led_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uzed_led_sequencer.sv
// uzed_led_sequencer: pattern generator and PWM dimmer for the eight UltraZed PL user LEDs.
// Patterns advance once per 2^PRESCALE_W cycles; mode/duty changes arrive over valid/ready.
module uzed_led_sequencer #(
  parameter int PRESCALE_W = 24
) (
  input  logic       clk_600,
  input  logic       RESET,
  input  logic       locked,
  input  logic [1:0] mode,
  input  logic [7:0] brightness,
  input  logic       mode_valid,
  output logic       mode_ready,
  output logic       step_tick,
  output logic [7:0] led
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RUN       = 2'd1,
    SWITCH    = 2'd2
  } state_e;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_COUNT   = 2'd1;
  localparam logic [1:0] MODE_SCAN    = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRESC_MAX = {PRESCALE_W{1'b1}};

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [7:0]            duty_q, duty_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [7:0]            pwm_q, pwm_d;
  logic [7:0]            count_q, count_d;
  logic [2:0]            pos_q, pos_d;
  logic                  scan_up_q, scan_up_d;
  logic [7:0]            ramp_q, ramp_d;
  logic                  ramp_up_q, ramp_up_d;
  logic [7:0]            led_q, led_d;
  logic                  ready_q, ready_d;
  logic                  tick_q, tick_d;

  logic                  accept_s;
  logic                  hold_run_s;
  logic [7:0]            pattern_s;
  logic [7:0]            duty_s;
  logic                  pwm_on_s;

  // Next-state logic for the FSM, prescaler, PWM counter, pattern state and outputs.
  always_comb begin
    accept_s = mode_valid && ready_q;

    if (!locked) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: state_d = RUN;
        RUN:       state_d = accept_s ? SWITCH : RUN;
        SWITCH:    state_d = RUN;
        default:   state_d = WAIT_LOCK;
      endcase
    end

    mode_d = accept_s ? mode : mode_q;
    duty_d = accept_s ? brightness : duty_q;

    // Anything other than staying in RUN leaves the pattern cleared, so an accept drops a coincident step.
    hold_run_s = (state_q == RUN) && (state_d == RUN);

    presc_d   = hold_run_s ? (presc_q + PRESC_ONE) : {PRESCALE_W{1'b0}};
    count_d   = count_q;
    pos_d     = pos_q;
    scan_up_d = scan_up_q;
    ramp_d    = ramp_q;
    ramp_up_d = ramp_up_q;

    if (hold_run_s && tick_q) begin
      count_d = count_q + 8'd1;
      if (scan_up_q) begin
        if (pos_q == 3'd7) begin
          pos_d     = 3'd6;
          scan_up_d = 1'b0;
        end else begin
          pos_d = pos_q + 3'd1;
        end
      end else begin
        if (pos_q == 3'd0) begin
          pos_d     = 3'd1;
          scan_up_d = 1'b1;
        end else begin
          pos_d = pos_q - 3'd1;
        end
      end
      if (ramp_up_q) begin
        if (ramp_q == 8'd248) begin
          ramp_d    = 8'd240;
          ramp_up_d = 1'b0;
        end else begin
          ramp_d = ramp_q + 8'd8;
        end
      end else begin
        if (ramp_q == 8'd0) begin
          ramp_d    = 8'd8;
          ramp_up_d = 1'b1;
        end else begin
          ramp_d = ramp_q - 8'd8;
        end
      end
    end else if (hold_run_s) begin
      count_d = count_q;
    end else begin
      count_d   = 8'd0;
      pos_d     = 3'd0;
      scan_up_d = 1'b1;
      ramp_d    = 8'd0;
      ramp_up_d = 1'b1;
    end

    pwm_d = ((state_q != WAIT_LOCK) && (state_d != WAIT_LOCK)) ? (pwm_q + 8'd1) : 8'd0;

    case (mode_q)
      MODE_OFF:     pattern_s = 8'h00;
      MODE_COUNT:   pattern_s = count_q;
      MODE_SCAN:    pattern_s = 8'd1 << pos_q;
      MODE_BREATHE: pattern_s = 8'hFF;
      default:      pattern_s = 8'h00;
    endcase
    duty_s   = (mode_q == MODE_BREATHE) ? ramp_q : duty_q;
    pwm_on_s = (pwm_q < duty_s);

    led_d   = (state_d == RUN) ? (pattern_s & {8{pwm_on_s}}) : 8'h00;
    ready_d = (state_d == RUN);
    tick_d  = (state_d == RUN) && (presc_d == PRESC_MAX);
  end

  // State and output registers.
  always_ff @(posedge clk_600 or posedge RESET) begin
    if (RESET) begin
      state_q   <= WAIT_LOCK;
      mode_q    <= MODE_COUNT;
      duty_q    <= 8'hFF;
      presc_q   <= {PRESCALE_W{1'b0}};
      pwm_q     <= 8'd0;
      count_q   <= 8'd0;
      pos_q     <= 3'd0;
      scan_up_q <= 1'b1;
      ramp_q    <= 8'd0;
      ramp_up_q <= 1'b1;
      led_q     <= 8'h00;
      ready_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      duty_q    <= duty_d;
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      count_q   <= count_d;
      pos_q     <= pos_d;
      scan_up_q <= scan_up_d;
      ramp_q    <= ramp_d;
      ramp_up_q <= ramp_up_d;
      led_q     <= led_d;
      ready_q   <= ready_d;
      tick_q    <= tick_d;
    end
  end

  assign mode_ready = ready_q;
  assign step_tick  = tick_q;
  assign led        = led_q;

endmodule

// File: tb/tb_uzed_led_sequencer.sv
// Self-checking bench for uzed_led_sequencer: table-driven mode requests, directed corner
// sequences and a randomized phase, all compared every cycle against a cycle-count model.
`timescale 1ns/1ps
module tb_uzed_led_sequencer;

  localparam int PW = 4;
  localparam int STEP = 16;

  logic       clk_600;
  logic       rst;
  logic       locked;
  logic [1:0] mode;
  logic [7:0] brightness;
  logic       mode_valid;
  logic       mode_ready;
  logic       step_tick;
  logic [7:0] led;

  uzed_led_sequencer #(.PRESCALE_W(PW)) dut (
    .clk_600   (clk_600),
    .RESET     (rst),
    .locked    (locked),
    .mode      (mode),
    .brightness(brightness),
    .mode_valid(mode_valid),
    .mode_ready(mode_ready),
    .step_tick (step_tick),
    .led       (led)
  );

  initial clk_600 = 1'b0;
  always #5 clk_600 = ~clk_600;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model: state 0 = waiting for lock, 1 = running, 2 = switching.
  // m_runc counts RUN cycles since the pattern was last cleared; steps = m_runc / STEP.
  int         m_st, m_runc, m_pwm, m_mode, m_duty;
  logic [7:0] exp_led;

  logic [7:0] win_or;
  int         win_on;
  int         tick_cnt;

  function automatic logic [7:0] pat_of(input int md, input int steps);
    int k;
    int p;
    logic [7:0] one;
    one = 8'd1;
    case (md)
      0: pat_of = 8'h00;
      1: pat_of = 8'(steps % 256);
      2: begin
        k = steps % 14;
        p = (k < 8) ? k : 14 - k;
        pat_of = one << p;
      end
      default: pat_of = 8'hFF;
    endcase
  endfunction

  function automatic int duty_of(input int md, input int dq, input int steps);
    int k;
    if (md == 3) begin
      k = steps % 62;
      duty_of = (k <= 31) ? 8 * k : 8 * (62 - k);
    end else begin
      duty_of = dq;
    end
  endfunction

  task automatic model_reset();
    m_st = 0; m_runc = 0; m_pwm = 0; m_mode = 1; m_duty = 255; exp_led = 8'h00;
  endtask

  task automatic model_step();
    bit acc;
    int nst;
    acc = mode_valid && (m_st == 1);
    if (!locked) nst = 0;
    else if (m_st == 1) nst = acc ? 2 : 1;
    else nst = 1;
    if (nst == 1)
      exp_led = (m_pwm < duty_of(m_mode, m_duty, m_runc / STEP)) ? pat_of(m_mode, m_runc / STEP) : 8'h00;
    else
      exp_led = 8'h00;
    if (acc) begin
      m_mode = int'(mode);
      m_duty = int'(brightness);
    end
    m_runc = (nst == 1 && m_st == 1) ? m_runc + 1 : 0;
    m_pwm  = (nst != 0 && m_st != 0) ? (m_pwm + 1) % 256 : 0;
    m_st   = nst;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare just after the edge.
  task automatic cycle();
    if (rst) model_reset();
    else model_step();
    @(posedge clk_600);
    #1;
    chk("mode_ready", {31'd0, mode_ready}, {31'd0, (m_st == 1)});
    chk("step_tick", {31'd0, step_tick}, {31'd0, (m_st == 1) && (m_runc % STEP == STEP - 1)});
    chk("led", {24'd0, led}, {24'd0, exp_led});
    win_or = win_or | led;
    if (led != 8'h00) win_on++;
    if (step_tick) tick_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic request(input logic [1:0] m, input logic [7:0] b);
    mode = m;
    brightness = b;
    mode_valid = 1'b1;
    cycle();
    mode_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] md;
    logic [7:0] br;
    int         steps;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{2'd1, 8'hFF, 3,   8'h03};
    tbl[1]  = '{2'd1, 8'hFF, 5,   8'h05};
    tbl[2]  = '{2'd1, 8'h00, 4,   8'h00};
    tbl[3]  = '{2'd1, 8'hFF, 256, 8'h00};
    tbl[4]  = '{2'd1, 8'hFF, 257, 8'h01};
    tbl[5]  = '{2'd2, 8'hFF, 0,   8'h01};
    tbl[6]  = '{2'd2, 8'hFF, 7,   8'h80};
    tbl[7]  = '{2'd2, 8'hFF, 8,   8'h40};
    tbl[8]  = '{2'd2, 8'hFF, 9,   8'h20};
    tbl[9]  = '{2'd2, 8'hFF, 14,  8'h01};
    tbl[10] = '{2'd2, 8'hFF, 15,  8'h02};
    tbl[11] = '{2'd3, 8'h00, 0,   8'h00};
    tbl[12] = '{2'd3, 8'h00, 31,  8'hFF};
    tbl[13] = '{2'd0, 8'hFF, 2,   8'h00};

    rst = 1'b1; locked = 1'b0; mode = 2'd0; brightness = 8'd0; mode_valid = 1'b0;
    win_or = 8'h00; win_on = 0; tick_cnt = 0;
    model_reset();
    run(3);
    rst = 1'b0;

    // Lock held low: dark LEDs and no ready.
    run(100);
    locked = 1'b1;
    cycle();
    chk("ready_after_lock", {31'd0, mode_ready}, 32'd1);

    // Default COUNT at full duty.
    tick_cnt = 0;
    run(3 * STEP);
    chk("ticks_in_48", tick_cnt, 32'd3);
    win_or = 8'h00;
    run(STEP);
    chk("default_count_3", {24'd0, win_or}, 32'h03);

    foreach (tbl[i]) begin
      request(tbl[i].md, tbl[i].br);
      cycle();
      run(tbl[i].steps * STEP);
      win_or = 8'h00;
      run(STEP);
      chk($sformatf("tbl%0d_pattern", i), {24'd0, win_or}, {24'd0, tbl[i].exp});
    end

    // SCAN at duty 128: on exactly half of a full PWM window.
    request(2'd2, 8'd128);
    cycle();
    win_on = 0;
    run(256);
    chk("scan_duty128_on", win_on, 32'd128);

    // Accept coinciding with step_tick at COUNT pattern 05.
    request(2'd1, 8'hFF);
    cycle();
    run(5 * STEP + STEP - 1);
    chk("tick_before_accept", {31'd0, step_tick}, 32'd1);
    request(2'd2, 8'hFF);
    chk("ready_low_switch", {31'd0, mode_ready}, 32'd0);
    chk("led_dark_switch", {24'd0, led}, 32'd0);
    cycle();
    chk("ready_back", {31'd0, mode_ready}, 32'd1);
    win_or = 8'h00;
    run(STEP);
    chk("scan_restart", {24'd0, win_or}, 32'h01);

    // Lock loss mid-SCAN at pos 5, then relock.
    request(2'd2, 8'hFF);
    cycle();
    run(5 * STEP);
    locked = 1'b0;
    cycle();
    chk("unlock_led", {24'd0, led}, 32'd0);
    chk("unlock_ready", {31'd0, mode_ready}, 32'd0);
    run(10);
    locked = 1'b1;
    cycle();
    win_or = 8'h00;
    run(STEP);
    chk("relock_scan", {24'd0, win_or}, 32'h01);

    // Lock loss during SWITCH keeps the latched mode.
    request(2'd3, 8'h10);
    locked = 1'b0;
    cycle();
    locked = 1'b1;
    run(40);

    // Asynchronous reset mid-operation, then default COUNT resumes.
    rst = 1'b1;
    #1;
    chk("async_rst_led", {24'd0, led}, 32'd0);
    chk("async_rst_ready", {31'd0, mode_ready}, 32'd0);
    cycle();
    rst = 1'b0;
    cycle();
    run(2 * STEP);
    win_or = 8'h00;
    run(STEP);
    chk("post_reset_count", {24'd0, win_or}, 32'h02);

    // Randomized traffic including held-high valid and brief lock drops.
    for (int i = 0; i < 3000; i++) begin
      locked     = ($urandom_range(0, 199) != 0);
      mode_valid = (i >= 1000 && i < 1020) ? 1'b1 : ($urandom_range(0, 47) == 0);
      mode       = 2'($urandom_range(0, 3));
      brightness = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
